// File: rtl/mem_arb_pkg.sv
// Shared encodings and defaults for the fetch/data memory port arbiter.
package mem_arb_pkg;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY_IF = 2'd1;
  localparam logic [1:0] ST_BUSY_DM = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    BUSY_IF = ST_BUSY_IF,
    BUSY_DM = ST_BUSY_DM
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  // Data wins unless fetch has already been passed over MAX_STREAK times.
  function automatic state_t arb_pick(input logic if_req, input logic dm_req,
                                      input logic streak_full);
    if (dm_req && !(if_req && streak_full)) return BUSY_DM;
    else if (if_req)                        return BUSY_IF;
    else                                    return IDLE;
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Busy-cycle watchdog: reloads on grant, counts down on cycles without an
// acknowledge, and flags expiry in the last allowed busy cycle.
module mem_arb_timer #(
  parameter int TIMEOUT = 16
)(
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] LOAD = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                 cnt <= LOAD;
    else if (clr)              cnt <= LOAD;
    else if (en && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch and data stages, holding
// the granted transaction on the port until acknowledge or timeout.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 16
)(
  input  logic          clk,
  input  logic          rstn,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ready,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ready,
  output logic [DW-1:0] dm_rdata,
  output logic          stall_if,
  output logic          stall_dm,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          bus_err
);

  localparam int SW = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  state_t        state;
  state_t        pick;
  logic [SW-1:0] streak;
  logic          streak_full;
  logic          busy;
  logic          grant;
  logic          tmo_exp;
  logic          timeout;
  logic          done;

  assign streak_full = (streak == STREAK_MAX);
  assign pick        = arb_pick(if_req, dm_req, streak_full);
  assign busy        = (state != IDLE);
  assign grant       = (state == IDLE) && (pick != IDLE);
  // A real acknowledge in the deadline cycle wins over the forced completion.
  assign timeout     = busy && tmo_exp && !mem_ready;
  assign done        = busy && (mem_ready || timeout);

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (grant),
    .en     (busy && !mem_ready),
    .expire (tmo_exp)
  );

  assign if_ready = (state == BUSY_IF) && (mem_ready || timeout);
  assign dm_ready = (state == BUSY_DM) && (mem_ready || timeout);
  assign if_rdata = ((state == BUSY_IF) && mem_ready) ? mem_rdata : '0;
  assign dm_rdata = ((state == BUSY_DM) && mem_ready) ? mem_rdata : '0;
  assign stall_if = if_req && !if_ready;
  assign stall_dm = dm_req && !dm_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      streak    <= '0;
      bus_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick == BUSY_DM) begin
            state     <= BUSY_DM;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            if (!if_req)          streak <= '0;
            else if (!streak_full) streak <= streak + 1'b1;
          end else if (pick == BUSY_IF) begin
            state     <= BUSY_IF;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            streak    <= '0;
          end
        end
        BUSY_IF, BUSY_DM: begin
          if (done) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
          if (timeout) bus_err <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: requester drivers push expectations, a memory model checks
// the port and answers with a per-request latency, a monitor checks completions.
module tb_mem_port_arbiter;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic        dm_ready;
  logic [31:0] dm_rdata;
  logic        stall_if, stall_dm;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        bus_err;

  mem_port_arbiter #(.AW(32), .DW(32), .MAX_STREAK(4), .TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .stall_if(stall_if), .stall_dm(stall_dm),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Initial memory image; the fetch region is never written.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h0000_3000) return 32'h2408_0005;
    return a * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  logic [31:0] dmodel [logic [31:0]];
  logic [31:0] mmem   [logic [31:0]];

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return dmodel.exists(a) ? dmodel[a] : init_word(a);
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mmem.exists(a) ? mmem[a] : init_word(a);
  endfunction

  // Scoreboards: memory-side request, latency choice, requester-side response.
  int          lat_if[$], lat_dm[$];
  logic [64:0] req_if[$], req_dm[$];
  logic [31:0] exp_if[$];
  logic [32:0] exp_dm[$];

  bit          log_own[$];
  int          log_start[$];
  logic [64:0] log_req[$];

  int rdy_if_cyc = 0, rdy_dm_cyc = 0, issue_if_cyc = 0, stall_if_cnt = 0;

  // ---------------- requester drivers ----------------
  task automatic fetch(input logic [31:0] a, input int lat);
    bit got = 0;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = a; issue_if_cyc = cyc;
    lat_if.push_back(lat);
    req_if.push_back({1'b0, a, 32'h0});
    exp_if.push_back((lat > TMO) ? 32'h0 : init_word(a));
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (if_ready && rstn) begin got = 1; break; end
    end
    if (!got) flag("fetch_wait_timeout");
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input int lat, input bit keep);
    bit got = 0;
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd;
    lat_dm.push_back(lat);
    req_dm.push_back({we, a, wd});
    if (lat > TMO)  exp_dm.push_back({1'b1, 32'h0});
    else if (we)    exp_dm.push_back({1'b0, 32'h0});
    else            exp_dm.push_back({1'b1, model_rd(a)});
    if (we && lat <= TMO) dmodel[a] = wd;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (dm_ready && rstn) begin got = 1; break; end
    end
    if (!got) flag("data_wait_timeout");
    if (!keep) begin
      @(posedge clk); #1;
      dm_req = 1'b0;
    end
  endtask

  // ---------------- memory model ----------------
  bit          m_active = 0;
  int          m_k = 0, m_lat = 1;
  logic [64:0] m_cur;

  task automatic mem_step();
    logic [64:0] r;
    bit own;
    if (!rstn) begin
      m_active = 0; mem_ready = 1'b0; mem_rdata = $urandom;
      return;
    end
    if (m_active && !mem_req) begin
      m_active = 0;
    end else if (m_active) begin
      m_k++;
      chk("mem_hold_addr", {32'h0, mem_addr}, {32'h0, m_cur[63:32]});
      chk("mem_hold_we_wd", {31'h0, mem_we, mem_wdata}, {31'h0, m_cur[64], m_cur[31:0]});
    end else if (mem_req) begin
      own = (mem_addr < 32'h1000);
      m_lat = 1; r = '0;
      if (own) begin
        if (lat_dm.size() == 0 || req_dm.size() == 0) flag("unexpected_dm_grant");
        else begin m_lat = lat_dm.pop_front(); r = req_dm.pop_front(); end
      end else begin
        if (lat_if.size() == 0 || req_if.size() == 0) flag("unexpected_if_grant");
        else begin m_lat = lat_if.pop_front(); r = req_if.pop_front(); end
      end
      m_cur = {mem_we, mem_addr, mem_wdata};
      chk("grant_addr", {32'h0, mem_addr}, {32'h0, r[63:32]});
      chk("grant_we_wd", {31'h0, mem_we, mem_wdata}, {31'h0, r[64], r[31:0]});
      log_own.push_back(own);
      log_start.push_back(cyc);
      log_req.push_back(m_cur);
      m_active = 1; m_k = 1;
    end
    // Stray acknowledges while idle must be ignored by the arbiter.
    mem_ready = (!m_active && ($urandom_range(0, 3) == 0));
    mem_rdata = $urandom;
    if (m_active && m_k == m_lat) begin
      mem_ready = 1'b1;
      if (m_cur[64]) mmem[m_cur[63:32]] = m_cur[31:0];
      else           mem_rdata = mem_rd(m_cur[63:32]);
    end
  endtask

  initial forever begin
    @(posedge clk); #1;
    mem_step();
  end

  // ---------------- monitor ----------------
  task automatic mon_step();
    logic [32:0] e;
    chk("stall_if", {63'h0, stall_if}, {63'h0, if_req && !if_ready});
    chk("stall_dm", {63'h0, stall_dm}, {63'h0, dm_req && !dm_ready});
    if (stall_if) stall_if_cnt++;
    if (if_ready) begin
      rdy_if_cyc = cyc;
      if (exp_if.size() == 0) flag("if_ready_unexpected");
      else chk("if_rdata", {32'h0, if_rdata}, {32'h0, exp_if.pop_front()});
    end else chk("if_rdata_idle", {32'h0, if_rdata}, 64'h0);
    if (dm_ready) begin
      rdy_dm_cyc = cyc;
      if (exp_dm.size() == 0) flag("dm_ready_unexpected");
      else begin
        e = exp_dm.pop_front();
        if (e[32]) chk("dm_rdata", {32'h0, dm_rdata}, {32'h0, e[31:0]});
      end
    end else chk("dm_rdata_idle", {32'h0, dm_rdata}, 64'h0);
  endtask

  initial forever begin
    @(negedge clk);
    if (rstn) mon_step();
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    log_own.delete(); log_start.delete(); log_req.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0] seq;
    #12;
    chk("rst_mem_req", {63'h0, mem_req}, 64'h0);
    chk("rst_mem_we", {63'h0, mem_we}, 64'h0);
    chk("rst_mem_addr", {32'h0, mem_addr}, 64'h0);
    chk("rst_mem_wdata", {32'h0, mem_wdata}, 64'h0);
    chk("rst_ready", {62'h0, if_ready, dm_ready}, 64'h0);
    chk("rst_rdata", {if_rdata, dm_rdata}, 64'h0);
    chk("rst_bus_err", {63'h0, bus_err}, 64'h0);
    @(negedge clk); rstn = 1'b1;
    repeat (3) @(posedge clk);

    // Single fetch with ack in the second busy cycle.
    clear_log();
    stall_if_cnt = 0;
    fetch(32'h0000_3000, 2);
    chk("fetch_grant_lat", 64'(log_start[0] - issue_if_cyc), 64'd1);
    chk("fetch_ready_lat", 64'(rdy_if_cyc - issue_if_cyc), 64'd2);
    chk("fetch_stall_cycles", 64'(stall_if_cnt), 64'd2);

    // Starvation guard: fetch held while data re-requests back to back.
    clear_log();
    fork
      fetch(32'h0000_3008, 1);
      for (int i = 0; i < 5; i++) data(1'b0, 32'(4 * i), 32'h0, 1, i < 4);
    join
    seq = '0;
    for (int i = 0; i < 6; i++) if (i < log_own.size()) seq[5-i] = log_own[i];
    chk("starve_grant_order", {58'h0, seq}, {58'h0, 6'b111101});

    // Simultaneous requests: data first (streak back at 0), fetch after an idle cycle.
    clear_log();
    fork
      fetch(32'h0000_3004, 2);
      data(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2, 1'b0);
    join
    if (log_own.size() >= 2) begin
      chk("simul_first_owner", {63'h0, log_own[0]}, 64'h1);
      chk("simul_first_req", {31'h0, log_req[0][64], log_req[0][63:32]}, {31'h0, 1'b1, 32'h10});
      chk("simul_first_wdata", {32'h0, log_req[0][31:0]}, {32'h0, 32'hDEAD_BEEF});
      chk("simul_second_owner", {63'h0, log_own[1]}, 64'h0);
      chk("simul_gap", 64'(log_start[1] - log_start[0]), 64'd3);
    end else flag("simul_grant_count");
    data(1'b0, 32'h0000_0010, 32'h0, 1, 1'b0);

    // Ack exactly in the deadline cycle completes normally.
    clear_log();
    data(1'b0, 32'h0000_0024, 32'h0, TMO, 1'b0);
    chk("deadline_lat", 64'(rdy_dm_cyc - log_start[0]), 64'(TMO - 1));
    repeat (2) @(negedge clk);
    chk("deadline_no_err", {63'h0, bus_err}, 64'h0);

    // Missing ack: forced completion with zero data, sticky error.
    clear_log();
    data(1'b0, 32'h0000_0020, 32'h0, 99, 1'b0);
    chk("timeout_lat", 64'(rdy_dm_cyc - log_start[0]), 64'(TMO - 1));
    repeat (2) @(negedge clk);
    chk("timeout_err_set", {63'h0, bus_err}, 64'h1);
    fetch(32'h0000_3010, 3);
    data(1'b0, 32'h0000_0020, 32'h0, 1, 1'b0);
    chk("timeout_err_sticky", {63'h0, bus_err}, 64'h1);

    // Randomized concurrent traffic.
    fork
      for (int i = 0; i < 150; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        fetch(32'h0000_3000 + 32'(4 * $urandom_range(0, 63)),
              ($urandom_range(0, 19) == 0) ? 20 : $urandom_range(1, 6));
      end
      for (int i = 0; i < 150; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        data(1'($urandom_range(0, 1)), 32'(4 * $urandom_range(0, 15)), $urandom,
             ($urandom_range(0, 19) == 0) ? 18 : $urandom_range(1, 6), 1'b0);
      end
    join
    repeat (4) @(posedge clk);

    // Reset while a fetch is in flight; the held request is re-arbitrated.
    fork
      fetch(32'h0000_3020, 99);
    join_none
    repeat (5) @(posedge clk);
    #2;
    chk("pre_reset_busy", {63'h0, mem_req}, 64'h1);
    rstn = 1'b0;
    #1;
    chk("reset_mem_req", {63'h0, mem_req}, 64'h0);
    chk("reset_if_ready", {63'h0, if_ready}, 64'h0);
    chk("reset_mem_addr", {32'h0, mem_addr}, 64'h0);
    chk("reset_bus_err", {63'h0, bus_err}, 64'h0);
    lat_if.delete(); req_if.delete(); exp_if.delete();
    lat_if.push_back(2);
    req_if.push_back({1'b0, 32'h0000_3020, 32'h0});
    exp_if.push_back(init_word(32'h0000_3020));
    mmem.delete();
    dmodel.delete();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    wait fork;
    repeat (3) @(posedge clk);
    chk("final_queues_empty", 64'(exp_if.size() + exp_dm.size() + lat_if.size() + lat_dm.size()), 64'h0);
    chk("final_no_err", {63'h0, bus_err}, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one shared single-ported unified memory between two pipeline requesters:
  - the fetch stage (instruction read);
  - the memory stage (data load/store).
- Holds the granted transaction registered on the memory port until the memory acknowledges it.
- Drives per-stage stall lines so the PC and pipeline registers freeze while a stage waits.
- Data beats fetch; a streak limit prevents fetch starvation, and a timeout recovers from a missing acknowledge.

Parameters:
AW, 32, address width
DW, 32, data width
MAX_STREAK, 4, max consecutive data grants while fetch is waiting
TIMEOUT, 16, cycles in a busy state before forced completion (≥2)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held with if_addr until if_ready
if_addr  in  AW  fetch address
if_ready  out  1  fetch completion pulse
if_rdata  out  DW  instruction word, valid with if_ready
dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata until dm_ready
dm_we  in  1  1=store, 0=load
dm_addr  in  AW  data address
dm_wdata  in  DW  store data
dm_ready  out  1  data completion pulse
dm_rdata  out  DW  load data, valid with dm_ready
stall_if  out  1  if_req && !if_ready
stall_dm  out  1  dm_req && !dm_ready
mem_req  out  1  memory transaction active
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data
mem_ready  in  1  memory acknowledge, one cycle, any cycle mem_req=1
bus_err  out  1  sticky timeout flag

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE; streak=0; timer=0; bus_err=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - if_ready=0, dm_ready=0; if_rdata and dm_rdata read 0.
- Reset mid-transaction abandons the transaction with no completion pulse. The memory model is reset on the same rstn.
- States: IDLE, BUSY_IF, BUSY_DM.
- IDLE arbitration is registered at the clock edge:
  - only dm_req → BUSY_DM;
  - only if_req → BUSY_IF;
  - both requesting and streak<MAX_STREAK → BUSY_DM;
  - both requesting and streak==MAX_STREAK → BUSY_IF;
  - neither → stay IDLE.
- At the grant edge:
  - mem_addr, mem_we and mem_wdata are captured from the winner; fetch grants force mem_we=0 and mem_wdata=0.
  - mem_req=1 from the next cycle.
  - Memory outputs stay constant while busy, even if requester inputs change.
- Streak counter:
  - data grant with if_req=1 → streak+1, saturating at MAX_STREAK;
  - data grant with if_req=0 → streak=0;
  - any fetch grant → streak=0.
- Completion, combinational:
  - if_ready = (state==BUSY_IF) && mem_ready;
  - dm_ready = (state==BUSY_DM) && mem_ready;
  - rdata outputs pass mem_rdata through while their ready is high, else 0.
  - dm_rdata is undefined-but-driven (mem_rdata) on store completion.
- Next edge after completion: state=IDLE, mem_req=0, mem_we=0.
  - Minimum access latency: 2 cycles (grant edge, ack cycle).
  - One mandatory IDLE cycle between transactions.
- Timer:
  - cleared at each grant; increments each busy cycle without mem_ready.
  - When timer==TIMEOUT-1 and no mem_ready: the owner's ready pulses that cycle with rdata=0, bus_err is set (sticky until reset), and state returns to IDLE.
  - mem_ready in that same cycle takes precedence: normal completion, no error.
- mem_ready while IDLE is ignored and raises no pulse.
- A requester dropping req while busy is a protocol violation; the transaction still completes on the memory side.
- stall_if and stall_dm are purely combinational from req and ready, so the stall drops in the completion cycle.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding constants: IDLE=2'd0, BUSY_IF=2'd1, BUSY_DM=2'd2;
  - owner constants;
  - default AW/DW.
- One natural sub-module, mem_arb_timer: the TIMEOUT down-counter with clear, enable and expire outputs.
- Arbitration, streak counter and port registers stay in the top module.

Test Plan:
- Single fetch: if_req=1, if_addr=0x0000_3000; memory acks 1 cycle after mem_req with 0x2408_0005 → mem_req rises 1 cycle after request; if_ready and if_rdata=0x2408_0005 arrive 2 cycles after request; stall_if high for exactly 2 cycles.
- Simultaneous requests: if_req and dm_req (store 0xDEAD_BEEF to 0x0000_0010) in the same cycle → mem_we=1, mem_addr=0x10, mem_wdata=0xDEADBEEF granted first; the fetch is granted after one IDLE cycle.
- Starvation: if_req held; dm_req re-asserted immediately after each dm_ready → exactly 4 data grants, then 1 fetch grant; streak returns to 0.
- Timeout: grant data load to 0x20, never assert mem_ready → dm_ready at the 16th busy cycle with dm_rdata=0; bus_err=1 and stays 1; the next transaction completes normally.
- Ack at the deadline: mem_ready in the 16th busy cycle → normal completion with mem_rdata; bus_err stays 0.
- Reset mid-op: rstn=0 during BUSY_IF → mem_req=0, if_ready=0, state=IDLE immediately (asynchronously); the request is re-arbitrated after rstn=1.
